// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite word-addressed RAM target: one-entry AW/W holding buffers, byte strobes,
// SLVERR for indices beyond DEPTH, and a fixed read latency of 1..4 cycles.
module axi4lite_mem_slave #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int MEM_RESET    = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY
);
    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int IDX_LSB = $clog2(STRB_W);
    localparam int IDX_W   = ADDR_WIDTH - IDX_LSB;
    localparam int MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = DEPTH;
    localparam logic [2:0]  LAT_INIT = 3'(READ_LATENCY - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RD_IDLE = 2'd0;
    localparam logic [1:0]  RD_WAIT = 2'd1;
    localparam logic [1:0]  RD_RESP = 2'd2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  awFull_q, awFull_d, awReady_q;
    logic [IDX_W-1:0]      awIdx_q, awIdx_d;
    logic                  wFull_q, wFull_d, wReady_q;
    logic [DATA_WIDTH-1:0] wData_q, wData_d;
    logic [STRB_W-1:0]     wStrb_q, wStrb_d;
    logic                  bValid_q, bValid_d;
    logic [1:0]            bResp_q, bResp_d;
    logic                  commit, wrInRange;

    logic [1:0]            rdState_q, rdState_d;
    logic [2:0]            rdCnt_q, rdCnt_d;
    logic [IDX_W-1:0]      arIdx_q, arIdx_d, rdIdx;
    logic                  arReady_q;
    logic [DATA_WIDTH-1:0] rData_q, rData_d;
    logic [1:0]            rResp_q, rResp_d;
    logic                  rdCapture, rdInRange;

    logic unused;
    assign unused = ^{AWPROT, ARPROT, AWADDR[IDX_LSB-1:0], ARADDR[IDX_LSB-1:0]};

    // A commit needs both buffers full and a free (or draining) B slot.
    assign commit    = awFull_q && wFull_q && (!bValid_q || BREADY);
    assign wrInRange = 32'(awIdx_q) < DEPTH_U;

    always_comb begin
        awFull_d = awFull_q;
        awIdx_d  = awIdx_q;
        wFull_d  = wFull_q;
        wData_d  = wData_q;
        wStrb_d  = wStrb_q;
        bValid_d = bValid_q;
        bResp_d  = bResp_q;
        if (AWVALID && awReady_q) begin
            awFull_d = 1'b1;
            awIdx_d  = AWADDR[ADDR_WIDTH-1:IDX_LSB];
        end
        if (WVALID && wReady_q) begin
            wFull_d = 1'b1;
            wData_d = WDATA;
            wStrb_d = WSTRB;
        end
        if (bValid_q && BREADY) begin
            bValid_d = 1'b0;
        end
        if (commit) begin
            awFull_d = 1'b0;
            wFull_d  = 1'b0;
            bValid_d = 1'b1;
            bResp_d  = wrInRange ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awFull_q  <= 1'b0;
            awReady_q <= 1'b0;
            awIdx_q   <= '0;
            wFull_q   <= 1'b0;
            wReady_q  <= 1'b0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bValid_q  <= 1'b0;
            bResp_q   <= 2'b00;
        end else begin
            awFull_q  <= awFull_d;
            awReady_q <= !awFull_d;
            awIdx_q   <= awIdx_d;
            wFull_q   <= wFull_d;
            wReady_q  <= !wFull_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            bValid_q  <= bValid_d;
            bResp_q   <= bResp_d;
        end
    end

    // In IDLE the index comes straight from ARADDR so latency 1 can capture at the handshake.
    assign rdIdx     = (rdState_q == RD_IDLE) ? ARADDR[ADDR_WIDTH-1:IDX_LSB] : arIdx_q;
    assign rdInRange = 32'(rdIdx) < DEPTH_U;

    always_comb begin
        rdState_d = rdState_q;
        rdCnt_d   = rdCnt_q;
        arIdx_d   = arIdx_q;
        rData_d   = rData_q;
        rResp_d   = rResp_q;
        rdCapture = 1'b0;
        case (rdState_q)
            RD_IDLE: begin
                if (ARVALID && arReady_q) begin
                    arIdx_d = rdIdx;
                    rdCnt_d = LAT_INIT;
                    if (LAT_INIT == 3'd0) begin
                        rdState_d = RD_RESP;
                        rdCapture = 1'b1;
                    end else begin
                        rdState_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                rdCnt_d = rdCnt_q - 3'd1;
                if (rdCnt_q == 3'd1) begin
                    rdState_d = RD_RESP;
                    rdCapture = 1'b1;
                end
            end
            RD_RESP: begin
                if (RREADY) begin
                    rdState_d = RD_IDLE;
                end
            end
            default: rdState_d = RD_IDLE;
        endcase
        if (rdCapture) begin
            rData_d = rdInRange ? mem[rdIdx[MEM_AW-1:0]] : '0;
            rResp_d = rdInRange ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdState_q <= RD_IDLE;
            rdCnt_q   <= 3'd0;
            arIdx_q   <= '0;
            arReady_q <= 1'b0;
            rData_q   <= '0;
            rResp_q   <= 2'b00;
        end else begin
            rdState_q <= rdState_d;
            rdCnt_q   <= rdCnt_d;
            arIdx_q   <= arIdx_d;
            arReady_q <= (rdState_d == RD_IDLE);
            rData_q   <= rData_d;
            rResp_q   <= rResp_d;
        end
    end

    // Non-blocking array update gives read-before-write on a same-edge capture.
    generate
        if (MEM_RESET != 0) begin : g_memReset
            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (commit && wrInRange) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wStrb_q[b]) begin
                            mem[awIdx_q[MEM_AW-1:0]][8*b +: 8] <= wData_q[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : g_memNoReset
            always_ff @(posedge ACLK) begin
                if (commit && wrInRange) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wStrb_q[b]) begin
                            mem[awIdx_q[MEM_AW-1:0]][8*b +: 8] <= wData_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    assign AWREADY = awReady_q;
    assign WREADY  = wReady_q;
    assign BVALID  = bValid_q;
    assign BRESP   = bResp_q;
    assign ARREADY = arReady_q;
    assign RVALID  = (rdState_q == RD_RESP);
    assign RDATA   = rData_q;
    assign RRESP   = rResp_q;
endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Directed bench: two slaves (read latency 1 and 3) share the write channel and reset;
// a vector table covers single write/read pairs, hand sequences cover multi-cycle cases.
module tb_axi4lite_mem_slave;
    localparam int AW = 13;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        logic [1:0]    expBresp;
        logic [31:0]   expRdata;
        logic [1:0]    expRresp;
    } vecRec_t;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [AW-1:0] AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID, AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID, WREADY;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;
    logic [AW-1:0] ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID, ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID, RREADY;

    logic          aw3Ready, w3Ready, b3Valid;
    logic [1:0]    b3Resp;
    logic [AW-1:0] ar3Addr;
    logic          ar3Valid, ar3Ready;
    logic [31:0]   r3Data;
    logic [1:0]    r3Resp;
    logic          r3Valid, r3Ready;

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    axi4lite_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(1), .MEM_RESET(1)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    axi4lite_mem_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .DEPTH(1024), .READ_LATENCY(3), .MEM_RESET(1)
    ) dut3 (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(aw3Ready),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(w3Ready),
        .BRESP(b3Resp), .BVALID(b3Valid), .BREADY(BREADY),
        .ARADDR(ar3Addr), .ARPROT(ARPROT), .ARVALID(ar3Valid), .ARREADY(ar3Ready),
        .RDATA(r3Data), .RRESP(r3Resp), .RVALID(r3Valid), .RREADY(r3Ready)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doWrite(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
        int n;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin
            tick();
            n++;
        end
        checkOutput("wrReady", 64'({AWREADY, WREADY}), 64'd3);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        checkOutput("bvalidEarly", 64'(BVALID), 64'd0);
        tick();
        checkOutput("bvalidRise", 64'(BVALID), 64'd1);
        resp = BRESP;
        tick();
        checkOutput("bvalidDrop", 64'(BVALID), 64'd0);
    endtask

    task automatic doRead(input logic [AW-1:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
        int n;
        ARADDR  = addr;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin
            tick();
            n++;
        end
        checkOutput("arReady", 64'(ARREADY), 64'd1);
        tick();
        ARVALID = 1'b0;
        checkOutput("rvalidRise", 64'(RVALID), 64'd1);
        data = RDATA;
        resp = RRESP;
        tick();
        checkOutput("rvalidDrop", 64'({RVALID, ARREADY}), 64'd1);
    endtask

    task automatic applyStimulus(input vecRec_t v, input int k);
        logic [1:0]  br, rr;
        logic [31:0] rd;
        doWrite(v.addr, v.wdata, v.strb, br);
        checkOutput($sformatf("vec%0d bresp", k), 64'(br), 64'(v.expBresp));
        doRead(v.addr, rd, rr);
        checkOutput($sformatf("vec%0d rdata", k), 64'(rd), 64'(v.expRdata));
        checkOutput($sformatf("vec%0d rresp", k), 64'(rr), 64'(v.expRresp));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecRec_t     vecs [8];
        logic [31:0] rd;
        logic [1:0]  rr;

        vecs[0] = '{13'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{13'h0014, 32'h12345678, 4'hF, 2'b00, 32'h12345678, 2'b00};
        vecs[2] = '{13'h0014, 32'hAABBCCDD, 4'h8, 2'b00, 32'hAA345678, 2'b00};
        vecs[3] = '{13'h0016, 32'h0000FFFF, 4'h3, 2'b00, 32'hAA34FFFF, 2'b00};
        vecs[4] = '{13'h0014, 32'hFFFFFFFF, 4'h0, 2'b00, 32'hAA34FFFF, 2'b00};
        vecs[5] = '{13'h0FFC, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D, 2'b00};
        vecs[6] = '{13'h1000, 32'h55555555, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[7] = '{13'h1FFE, 32'h12345678, 4'hF, 2'b10, 32'h00000000, 2'b10};

        ARESETN = 1'b0;
        AWADDR = '0; AWPROT = 3'd0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = 3'd0; ARVALID = 1'b0; RREADY = 1'b0;
        ar3Addr = '0; ar3Valid = 1'b0; r3Ready = 1'b0;
        tick();
        tick();

        checkOutput("rstReadies", 64'({AWREADY, WREADY, ARREADY, ar3Ready}), 64'd0);
        checkOutput("rstValids", 64'({BVALID, RVALID, r3Valid}), 64'd0);
        checkOutput("rstResp", 64'({BRESP, RRESP}), 64'd0);
        checkOutput("rstRdata", 64'(RDATA), 64'd0);
        ARESETN = 1'b1;
        checkOutput("readyBeforeEdge", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
        tick();
        checkOutput("readyAfterEdge", 64'({AWREADY, WREADY, ARREADY, ar3Ready}), 64'hF);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k], k);
        end

        // Out-of-range writes must not alias onto low or top indices.
        for (int i = 0; i < 4; i++) begin
            doRead(AW'(4 * i), rd, rr);
            checkOutput($sformatf("sweep%0d", i), 64'(rd), 64'd0);
        end
        doRead(13'h0FFC, rd, rr);
        checkOutput("topWordKept", 64'(rd), 64'hCAFEF00D);

        // W leads AW by three cycles.
        BREADY = 1'b1;
        WDATA  = 32'h11223344;
        WSTRB  = 4'b0101;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        checkOutput("wLeadWready", 64'({WREADY, AWREADY}), 64'd1);
        tick();
        tick();
        checkOutput("wLeadHold", 64'({WREADY, BVALID}), 64'd0);
        AWADDR  = 13'h0010;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checkOutput("wLeadNoBYet", 64'(BVALID), 64'd0);
        tick();
        checkOutput("wLeadBvalid", 64'({BVALID, BRESP, WREADY}), 64'b1001);
        tick();
        doRead(13'h0010, rd, rr);
        checkOutput("wLeadData", 64'(rd), 64'hDE22BE44);

        // B backpressure: second write parks in the buffers until BREADY returns.
        BREADY  = 1'b0;
        AWADDR  = 13'h0020;
        WDATA   = 32'h11111111;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        tick();
        checkOutput("bpFirstB", 64'({BVALID, BRESP}), 64'b100);
        AWADDR  = 13'h1000;
        WDATA   = 32'h99999999;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("bpHoldB", 64'({BVALID, BRESP}), 64'b100);
            checkOutput("bpBufFull", 64'({AWREADY, WREADY}), 64'd0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        checkOutput("bpSecondB", 64'({BVALID, BRESP}), 64'b110);
        tick();
        checkOutput("bpSecondDrop", 64'(BVALID), 64'd0);
        doRead(13'h0020, rd, rr);
        checkOutput("bpData", 64'(rd), 64'h11111111);

        // Latency 3 with RREADY low; a write commits on the capture edge.
        r3Ready  = 1'b0;
        ar3Addr  = 13'h0014;
        ar3Valid = 1'b1;
        checkOutput("rl3ArReady", 64'(ar3Ready), 64'd1);
        tick();
        ar3Valid = 1'b0;
        checkOutput("rl3Wait1", 64'({ar3Ready, r3Valid}), 64'd0);
        AWADDR  = 13'h0014;
        WDATA   = 32'h0BADF00D;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        checkOutput("rl3Wait2", 64'({ar3Ready, r3Valid}), 64'd0);
        tick();
        checkOutput("rl3Rvalid", 64'({r3Valid, r3Resp}), 64'b100);
        checkOutput("rl3OldData", 64'(r3Data), 64'hAA34FFFF);
        checkOutput("rl3Commit", 64'(BVALID), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rl3Hold", 64'({r3Valid, ar3Ready}), 64'b10);
            checkOutput("rl3HoldData", 64'(r3Data), 64'hAA34FFFF);
        end
        r3Ready = 1'b1;
        tick();
        checkOutput("rl3Done", 64'({ar3Ready, r3Valid}), 64'b10);
        doRead(13'h0014, rd, rr);
        checkOutput("rl3NewData", 64'(rd), 64'h0BADF00D);

        // Reset while B is pending and the latency-3 read sits in WAIT.
        BREADY   = 1'b0;
        AWADDR   = 13'h0030;
        WDATA    = 32'h77777777;
        AWVALID  = 1'b1;
        WVALID   = 1'b1;
        ar3Addr  = 13'h0010;
        ar3Valid = 1'b1;
        tick();
        AWVALID  = 1'b0;
        WVALID   = 1'b0;
        ar3Valid = 1'b0;
        tick();
        checkOutput("preRstState", 64'({BVALID, ar3Ready, r3Valid}), 64'b100);
        #1 ARESETN = 1'b0;
        #1;
        checkOutput("rstAsyncDut", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 64'd0);
        checkOutput("rstAsyncDut3",
                    64'({aw3Ready, w3Ready, ar3Ready, b3Valid, r3Valid, b3Resp}), 64'd0);
        tick();
        ARESETN = 1'b1;
        BREADY  = 1'b1;
        tick();
        doRead(13'h0010, rd, rr);
        checkOutput("postRst010", 64'(rd), 64'd0);
        doRead(13'h0014, rd, rr);
        checkOutput("postRst014", 64'(rd), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
